// File: rtl/paddsb_serial_unit_pkg.sv
// Shared constants for the serial packed-nibble saturating add/subtract unit.
package paddsb_serial_unit_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NUM_NIB = 4;
    localparam int unsigned DATA_W  = NIB_W * NUM_NIB;
    localparam int unsigned LANE_W  = $clog2(NUM_NIB);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [NIB_W-1:0] SAT_POS = 4'h7;
    localparam logic [NIB_W-1:0] SAT_NEG = 4'h8;

endpackage

// File: rtl/adder_4bit.sv
// Combinational signed 4-bit adder with carry-in that clamps overflow to 0x7 / 0x8.
module adder_4bit
    import paddsb_serial_unit_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;
    logic [4:0] sext;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        sext = {a[3], a} + {b[3], b} + {4'b0, cin};
        cout = raw[4];
        // Sign bit disagreeing with bit 3 of the extended sum means signed overflow.
        if (sext[4] != sext[3]) begin
            sum = sext[4] ? SAT_NEG : SAT_POS;
        end else begin
            sum = sext[3:0];
        end
    end

endmodule

// File: rtl/paddsb_serial_unit.sv
// Serial PADDSB unit: one nibble lane per cycle through a shared saturating
// adder, result returned via valid/ready.
module paddsb_serial_unit
    import paddsb_serial_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_sub,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              sub_q, sub_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [NIB_W-1:0]  add_a;
    logic [NIB_W-1:0]  add_b;
    logic [NIB_W-1:0]  add_sum;
    logic              unused_cout;

    always_comb begin
        add_a = a_q[lane_q*NIB_W +: NIB_W];
        add_b = b_q[lane_q*NIB_W +: NIB_W];
        if (sub_q) begin
            add_b = ~add_b;
        end
    end

    adder_4bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (sub_q),
        .sum  (add_sum),
        .cout (unused_cout)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                // Flush squashes an accept presented in the same cycle.
                if (in_valid && !flush) begin
                    a_d      = a;
                    b_d      = b;
                    sub_d    = op_sub;
                    lane_d   = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d[lane_q*NIB_W +: NIB_W] = add_sum;
                    lane_d = lane_q + 1'b1;
                    if (lane_q == LANE_W'(NUM_NIB - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lane_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_paddsb_serial_unit.sv
// Self-checking bench for paddsb_serial_unit: vector table, random traffic
// against a lane-arithmetic model, and hand-written control sequences.
module tb_paddsb_serial_unit;
    import paddsb_serial_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              op_sub;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    paddsb_serial_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-lane signed arithmetic, clamped to the 4-bit signed range.
    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < NUM_NIB; i++) begin
            int va;
            int vb;
            int v;
            logic [3:0] na;
            logic [3:0] nb;
            na = x[i*4 +: 4];
            nb = y[i*4 +: 4];
            va = int'($signed(na));
            vb = int'($signed(nb));
            v  = s ? va - vb : va + vb;
            if (v > 7) r[i*4 +: 4] = SAT_POS;
            else if (v < -8) r[i*4 +: 4] = SAT_NEG;
            else r[i*4 +: 4] = v[3:0];
        end
        return r;
    endfunction

    // Accept at the next edge, check 5-cycle latency, stall, check result, drain.
    task automatic do_txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input int stall, input logic [15:0] exp, input string name);
        int n;
        @(negedge clk);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        a = ta;
        b = tb_v;
        op_sub = ts;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        op_sub = 1'($urandom);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd5);
        repeat (stall) @(negedge clk);
        check({name, " result"}, 32'(result), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        logic [15:0] ra, rb, held;
        logic        rs;
        logic        saw_valid;
        int          n;

        vecs.push_back('{16'h1234, 16'h1111, 1'b0, 16'h2345});
        vecs.push_back('{16'h7777, 16'h1111, 1'b0, 16'h7777});
        vecs.push_back('{16'h8888, 16'hFFFF, 1'b0, 16'h8888});
        vecs.push_back('{16'h7F08, 16'h1181, 1'b0, 16'h7089});
        vecs.push_back('{16'h00FF, 16'h0011, 1'b0, 16'h0000});
        vecs.push_back('{16'h0000, 16'h8888, 1'b1, 16'h7777});
        vecs.push_back('{16'h8530, 16'h1213, 1'b1, 16'h832D});
        vecs.push_back('{16'h8000, 16'h1000, 1'b1, 16'h8000});

        rst_n = 1'b0;
        in_valid = 1'b0;
        op_sub = 1'b0;
        a = '0;
        b = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_txn(vecs[i].a, vecs[i].b, vecs[i].sub, i % 3, vecs[i].exp,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            do_txn(ra, rb, rs, int'($urandom_range(0, 3)), model(ra, rb, rs),
                   $sformatf("rand%0d", i));
        end

        // Backpressure: DONE holds while out_ready is low; in_valid ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; op_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp reached done", 32'(out_valid), 32'd1);
        held = model(16'h1234, 16'h1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'hFFFF; b = 16'hFFFF;
            @(negedge clk);
            check("bp result", 32'(result), 32'(held));
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp no stray accept", 32'(busy), 32'd0);

        // Flush in the second RUN cycle.
        a = 16'h7F08; b = 16'h1181; op_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("flush run busy", 32'(busy), 32'd1);
        saw_valid = out_valid;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush idle in_ready", 32'(in_ready), 32'd1);
        check("flush idle busy", 32'(busy), 32'd0);
        repeat (6) begin
            @(negedge clk);
            saw_valid = saw_valid | out_valid;
        end
        check("flush no out_valid", 32'(saw_valid), 32'd0);

        // Flush overrides an accept in IDLE.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush blocks accept", 32'(busy), 32'd0);

        // Flush with out_ready in DONE: flush wins, unit returns to IDLE.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("flush done reached", 32'(out_valid), 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush done out_valid", 32'(out_valid), 32'd0);
        check("flush done in_ready", 32'(in_ready), 32'd1);

        // Async reset mid-RUN, away from any clock edge.
        @(negedge clk);
        a = 16'h8888; b = 16'hFFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset busy", 32'(busy), 32'd0);
        check("areset in_ready", 32'(in_ready), 32'd1);
        check("areset out_valid", 32'(out_valid), 32'd0);
        check("areset result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(16'h1234, 16'h1111, 1'b0, 0, 16'h2345, "post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
